trap_filter_v3: RTL and testbench

//  Parametrised trapezoidal shaping filter for ADC samples with pole-zero (M) correction.
//  k, l, M and the peak threshold are programmed at run time over a config strobe.

---
 rtl/trap_filter_v3_if.sv | 33 +++
 rtl/trap_filter_v3.sv | 180 ++++++++++++++++++
 tb/tb_trap_filter_v3.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/trap_filter_v3_if.sv
// Config, sample-in, shaped-out and peak-report signals of trap_filter_v3.
// The filter attaches to the slave modport; the sample/config source attaches to master.
interface trap_filter_v3_if #(
  parameter int unsigned ADC_W = 12,
  parameter int unsigned KL_W  = 7,
  parameter int unsigned M_W   = 10,
  parameter int unsigned OUT_W = 20
);
  logic                    cfg_wr;
  logic [KL_W-1:0]         cfg_k;
  logic [KL_W-1:0]         cfg_l;
  logic [M_W-1:0]          cfg_m;
  logic signed [OUT_W-1:0] cfg_thr;
  logic                    cfg_err;
  logic                    in_valid;
  logic signed [ADC_W-1:0] in_data;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic                    peak_valid;
  logic signed [OUT_W-1:0] peak_data;
  logic [15:0]             peak_width;

  modport slave (
    input  cfg_wr, cfg_k, cfg_l, cfg_m, cfg_thr, in_valid, in_data,
    output cfg_err, out_valid, out_data, out_sat, peak_valid, peak_data, peak_width
  );

  modport master (
    output cfg_wr, cfg_k, cfg_l, cfg_m, cfg_thr, in_valid, in_data,
    input  cfg_err, out_valid, out_data, out_sat, peak_valid, peak_data, peak_width
  );
endinterface

// File: rtl/trap_filter_v3.sv
// Trapezoidal shaper with pole-zero correction, output clipping, warm-up gating
// and a threshold peak detector; k/l/M/threshold are loaded over a config strobe.
module trap_filter_v3 #(
  parameter int unsigned ADC_W     = 12,
  parameter int unsigned MAX_DEPTH = 64,
  parameter int unsigned KL_W      = 7,
  parameter int unsigned M_W       = 10,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_W     = 20,
  parameter int unsigned SHIFT     = 4
) (
  input  logic clk,
  input  logic reset,
  trap_filter_v3_if.slave bus
);

  typedef enum logic {PK_IDLE, PK_ABOVE} pk_state_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam logic [KL_W:0] DEPTH_LIM = (KL_W+1)'(MAX_DEPTH);
  localparam acc_t OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam acc_t OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [KL_W-1:0]         k_q, l_q, kl_q;
  logic [M_W-1:0]          m_q;
  logic signed [OUT_W-1:0] thr_q;

  logic signed [ADC_W-1:0] dl_q [0:MAX_DEPTH];
  logic [5:0]              v_q, w_q;
  logic [KL_W-1:0]         warm_cnt_q;

  acc_t d1_q, d2_q, dd_q, p_q, m1_q, r_q, s_q;
  acc_t d1_d, d2_d, dd_d, p_d, m1_d, r_d, s_d, sh, m_ext;

  logic                    out_valid_q, out_sat_q, out_sat_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    cfg_err_q;

  pk_state_t               pk_q;
  logic signed [OUT_W-1:0] pk_max_q;
  logic [15:0]             pk_cnt_q;
  logic                    peak_valid_q;
  logic signed [OUT_W-1:0] peak_data_q;
  logic [15:0]             peak_width_q;

  logic cfg_ok, accept, warm;

  function automatic acc_t sx(input logic signed [ADC_W-1:0] x);
    return {{(ACC_W-ADC_W){x[ADC_W-1]}}, x};
  endfunction

  always_comb begin
    cfg_ok = bus.cfg_wr && (bus.cfg_k != '0) && (bus.cfg_l != '0) &&
             (({1'b0, bus.cfg_k} + {1'b0, bus.cfg_l}) <= DEPTH_LIM);
    accept = bus.in_valid && !bus.cfg_wr;
    // warm_cnt_q stops at k+l, so a sample arriving there is the (k+l+1)th
    warm   = (warm_cnt_q == kl_q);
    m_ext  = {{(ACC_W-M_W){1'b0}}, m_q};

    d1_d = sx(dl_q[0]) - sx(dl_q[l_q]);
    d2_d = sx(dl_q[k_q]) - sx(dl_q[kl_q]);
    dd_d = d1_q - d2_q;
    p_d  = p_q + dd_q;
    m1_d = dd_q * m_ext;
    r_d  = p_q + m1_q;
    s_d  = s_q + r_q;

    sh         = s_q >>> SHIFT;
    out_sat_d  = 1'b1;
    out_data_d = sh[OUT_W-1:0];
    if (sh > OUT_MAX) begin
      out_data_d = OUT_MAX[OUT_W-1:0];
    end else if (sh < OUT_MIN) begin
      out_data_d = OUT_MIN[OUT_W-1:0];
    end else begin
      out_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cfg_ok) begin
      // An accepted config clears exactly what reset clears, but keeps the new config
      if (reset) begin
        k_q   <= KL_W'(4);
        l_q   <= KL_W'(2);
        kl_q  <= KL_W'(6);
        m_q   <= '0;
        thr_q <= '0;
      end else begin
        k_q   <= bus.cfg_k;
        l_q   <= bus.cfg_l;
        kl_q  <= bus.cfg_k + bus.cfg_l;
        m_q   <= bus.cfg_m;
        thr_q <= bus.cfg_thr;
      end
      for (int unsigned j = 0; j <= MAX_DEPTH; j++) dl_q[j] <= '0;
      v_q          <= '0;
      w_q          <= '0;
      warm_cnt_q   <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      dd_q         <= '0;
      p_q          <= '0;
      m1_q         <= '0;
      r_q          <= '0;
      s_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      pk_q         <= PK_IDLE;
      pk_max_q     <= '0;
      pk_cnt_q     <= '0;
      peak_valid_q <= 1'b0;
      peak_data_q  <= '0;
      peak_width_q <= '0;
    end else begin
      cfg_err_q <= bus.cfg_wr;
      v_q       <= {v_q[4:0], accept};
      w_q       <= {w_q[4:0], accept && warm};

      if (accept) begin
        for (int unsigned j = 1; j <= MAX_DEPTH; j++) dl_q[j] <= dl_q[j-1];
        dl_q[0] <= bus.in_data;
        if (!warm) warm_cnt_q <= warm_cnt_q + KL_W'(1);
      end
      if (v_q[0]) begin
        d1_q <= d1_d;
        d2_q <= d2_d;
      end
      if (v_q[1]) dd_q <= dd_d;
      if (v_q[2]) begin
        p_q  <= p_d;
        m1_q <= m1_d;
      end
      if (v_q[3]) r_q <= r_d;
      if (v_q[4]) s_q <= s_d;

      out_valid_q <= v_q[5] && w_q[5];
      if (v_q[5] && w_q[5]) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end

      peak_valid_q <= 1'b0;
      if (out_valid_q) begin
        case (pk_q)
          PK_IDLE: begin
            if (out_data_q > thr_q) begin
              pk_q     <= PK_ABOVE;
              pk_max_q <= out_data_q;
              pk_cnt_q <= 16'd1;
            end
          end
          PK_ABOVE: begin
            if (out_data_q > thr_q) begin
              if (out_data_q > pk_max_q) pk_max_q <= out_data_q;
              if (pk_cnt_q != '1) pk_cnt_q <= pk_cnt_q + 16'd1;
            end else begin
              pk_q         <= PK_IDLE;
              peak_valid_q <= 1'b1;
              peak_data_q  <= pk_max_q;
              peak_width_q <= pk_cnt_q;
            end
          end
          default: pk_q <= PK_IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_err    = cfg_err_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_data  = peak_data_q;
  assign bus.peak_width = peak_width_q;

endmodule

// File: tb/tb_trap_filter_v3.sv
// Directed bench for trap_filter_v3: hand-computed shaped outputs, latency/gap
// timing, config accept/reject, warm-up length, clipping and peak reports.
module tb_trap_filter_v3;
  localparam int unsigned ADC_W     = 12;
  localparam int unsigned MAX_DEPTH = 64;
  localparam int unsigned KL_W      = 7;
  localparam int unsigned M_W       = 10;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned OUT_W     = 20;
  localparam int unsigned SHIFT     = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trap_filter_v3_if #(.ADC_W(ADC_W), .KL_W(KL_W), .M_W(M_W), .OUT_W(OUT_W)) bus ();

  trap_filter_v3 #(
    .ADC_W(ADC_W), .MAX_DEPTH(MAX_DEPTH), .KL_W(KL_W), .M_W(M_W),
    .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int oq_data[$], oq_sat[$], oq_cyc[$], pk_data[$], pk_width[$], in_cyc[$], exp_q[$];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      oq_data.push_back(int'(bus.out_data));
      oq_sat.push_back(int'(bus.out_sat));
      oq_cyc.push_back(cyc);
    end
    if (bus.peak_valid === 1'b1) begin
      pk_data.push_back(int'(bus.peak_data));
      pk_width.push_back(int'(bus.peak_width));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick(input logic v, input int data);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = data[ADC_W-1:0];
    if (v) in_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0);
  endtask

  task automatic clr();
    oq_data.delete(); oq_sat.delete(); oq_cyc.delete();
    pk_data.delete(); pk_width.delete(); in_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg(input int k, input int l, input int m, input int thr,
                     input logic exp_err, input string tag);
    @(negedge clk);
    bus.cfg_k    = k[KL_W-1:0];
    bus.cfg_l    = l[KL_W-1:0];
    bus.cfg_m    = m[M_W-1:0];
    bus.cfg_thr  = thr[OUT_W-1:0];
    bus.cfg_wr   = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    check(tag, bus.cfg_err, exp_err);
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_len"}, oq_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < oq_data.size(); i++)
      check($sformatf("%s[%0d]", tag, i), oq_data[i], exp_q[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cfg_err"},    bus.cfg_err, 1'b0);
    check({tag, "_out_valid"},  bus.out_valid, 1'b0);
    check({tag, "_out_data"},   bus.out_data, 0);
    check({tag, "_out_sat"},    bus.out_sat, 1'b0);
    check({tag, "_peak_valid"}, bus.peak_valid, 1'b0);
    check({tag, "_peak_data"},  bus.peak_data, 0);
    check({tag, "_peak_width"}, bus.peak_width, 0);
  endtask

  initial begin
    int gaps[7];
    gaps = '{1, 2, 3, 1, 2, 3, 1};
    reset = 1'b1;
    bus.cfg_wr = 1'b0; bus.cfg_k = '0; bus.cfg_l = '0; bus.cfg_m = '0; bus.cfg_thr = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;

    // Reset while samples are streaming and the output is live
    repeat (14) tick(1'b1, 100);
    tick(1'b1, 100);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    reset = 1'b0;
    bus.in_valid = 1'b0;
    clr();
    repeat (6) tick(1'b1, 5);
    idle(10);
    check("warm6_none", oq_data.size(), 0);
    tick(1'b1, 5);
    idle(10);
    check("warm7_one", oq_data.size(), 1);

    // Step 0 -> 160 -> 0 with k=4, l=2, M=0
    do_reset();
    clr();
    repeat (7) tick(1'b1, 0);
    repeat (10) tick(1'b1, 160);
    repeat (10) tick(1'b1, 0);
    idle(10);
    exp_q = '{0, 10, 30, 50, 70, 80, 80, 80, 80, 80, 80, 70, 50, 30, 10, 0, 0, 0, 0, 0, 0};
    check_outs("step");
    if (oq_cyc.size() > 1 && in_cyc.size() > 7)
      check("step_latency", oq_cyc[1] - in_cyc[7], 7);
    else
      check("step_latency_missing", oq_cyc.size(), 2);

    // Rejected configs; the sample in the strobe cycle is dropped
    clr();
    @(negedge clk);
    bus.cfg_k = 7'd60; bus.cfg_l = 7'd10; bus.cfg_m = 10'd5; bus.cfg_thr = 20'd7;
    bus.cfg_wr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 12'sd999;
    @(negedge clk);
    bus.cfg_wr = 1'b0; bus.in_valid = 1'b0;
    check("cfg_err_kl70", bus.cfg_err, 1'b1);
    @(negedge clk);
    check("cfg_err_1cyc", bus.cfg_err, 1'b0);
    cfg(0, 3, 1, 0, 1'b1, "cfg_err_k0");
    idle(10);
    check("cfg_sample_dropped", oq_data.size(), 0);
    // Old config (k=4,l=2,M=0) still active and no warm-up restart
    tick(1'b1, 160);
    repeat (7) tick(1'b1, 0);
    idle(10);
    exp_q = '{10, 20, 20, 20, 10, 0, 0, 0};
    check_outs("imp_m0");

    // Impulse with M=1, threshold above every output
    cfg(4, 2, 1, 5, 1'b0, "cfg_ok_thr5");
    clr();
    repeat (8) tick(1'b1, 0);
    tick(1'b1, 16);
    repeat (7) tick(1'b1, 0);
    idle(10);
    exp_q = '{0, 0, 2, 3, 2, 2, 0, -1, 0, 0};
    check_outs("imp_m1");
    check("peak_none_thr5", pk_data.size(), 0);

    // Same impulse with input gaps and thr=1
    cfg(4, 2, 1, 1, 1'b0, "cfg_ok_thr1");
    clr();
    repeat (7) tick(1'b1, 0);
    tick(1'b1, 16);
    for (int i = 0; i < 7; i++) begin
      idle(gaps[i]);
      tick(1'b1, 0);
    end
    idle(12);
    exp_q = '{0, 2, 3, 2, 2, 0, -1, 0, 0};
    check_outs("imp_gap");
    for (int i = 0; i < oq_cyc.size() && i + 6 < in_cyc.size(); i++)
      check($sformatf("gap_cyc[%0d]", i), oq_cyc[i] - in_cyc[i+6], 7);
    check("peak_count", pk_data.size(), 1);
    if (pk_data.size() > 0) begin
      check("peak_data", pk_data[0], 3);
      check("peak_width", pk_width[0], 4);
    end

    // Long filter, large M: flush, 17-sample warm-up, output clipping
    cfg(8, 8, 1023, 0, 1'b0, "cfg_ok_k8l8");
    check("flush_peak_data", bus.peak_data, 0);
    check("flush_peak_width", bus.peak_width, 0);
    clr();
    repeat (16) tick(1'b1, 0);
    idle(10);
    check("warm16_none", oq_data.size(), 0);
    tick(1'b1, 0);
    idle(10);
    check("warm17_one", oq_data.size(), 1);
    clr();
    repeat (24) tick(1'b1, 2047);
    idle(10);
    check("sat_len", oq_data.size(), 24);
    if (oq_data.size() == 24) begin
      check("sat_d0", oq_data[0], 131008);
      check("sat_s0", oq_sat[0], 0);
      check("sat_d1", oq_data[1], 262143);
      check("sat_d2", oq_data[2], 393407);
      check("sat_s2", oq_sat[2], 0);
      check("sat_d3", oq_data[3], 524287);
      check("sat_s3", oq_sat[3], 1);
      check("sat_d15", oq_data[15], 8188);
      check("sat_d23", oq_data[23], 8188);
      check("sat_s23", oq_sat[23], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
